// File: rtl/calendar_set_ctrl_pkg.sv
// Shared types, field codes, month constants and the month-length rule for the
// date-entry controller; the calendar core reuses days_in_month.
package calendar_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EDIT_DAY   = 3'd1,
        ST_EDIT_MONTH = 3'd2,
        ST_EDIT_YEAR  = 3'd3,
        ST_COMMIT     = 3'd4
    } state_t;

    localparam logic [1:0] FLD_NONE  = 2'd0;
    localparam logic [1:0] FLD_DAY   = 2'd1;
    localparam logic [1:0] FLD_MONTH = 2'd2;
    localparam logic [1:0] FLD_YEAR  = 2'd3;

    localparam logic [3:0] MONTH_JAN = 4'd1;
    localparam logic [3:0] MONTH_FEB = 4'd2;
    localparam logic [3:0] MONTH_APR = 4'd4;
    localparam logic [3:0] MONTH_JUN = 4'd6;
    localparam logic [3:0] MONTH_SEP = 4'd9;
    localparam logic [3:0] MONTH_NOV = 4'd11;
    localparam logic [3:0] MONTH_DEC = 4'd12;

    // Leap years are those whose two low year bits are zero.
    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [1:0] year_lo);
        logic [4:0] len;
        case (month)
            MONTH_FEB: len = (year_lo == 2'd0) ? 5'd29 : 5'd28;
            MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: len = 5'd30;
            default: len = 5'd31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/calendar_set_ctrl_if.sv
// Button/date bus between the debouncers + calendar (master side) and the
// date-entry controller (slave side).
interface calendar_set_ctrl_if #(
    parameter int YEARRES = 12
);
    logic                 btn_mode;
    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_cancel;
    logic [YEARRES+8:0]   date_cur;
    logic [YEARRES+8:0]   date_in;
    logic                 date_ow;
    logic [1:0]           edit_field;
    logic                 busy;

    modport master (
        output btn_mode, btn_up, btn_down, btn_cancel, date_cur,
        input  date_in, date_ow, edit_field, busy
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, btn_cancel, date_cur,
        output date_in, date_ow, edit_field, busy
    );
endinterface

// File: rtl/calendar_set_ctrl_month_len.sv
// Combinational month length: month number plus leap flag -> last legal day.
module calendar_set_ctrl_month_len
    import calendar_set_ctrl_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] max_day
);

    assign max_day = days_in_month(month, leap ? 2'd0 : 2'd1);

endmodule

// File: rtl/calendar_set_ctrl.sv
// Date-entry controller: walks day -> month -> year editing from button pulses,
// keeps the edited date legal at every step and commits it with a one-cycle date_ow.
module calendar_set_ctrl
    import calendar_set_ctrl_pkg::*;
#(
    parameter int YEARRES     = 12,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    calendar_set_ctrl_if.slave bus
);

    localparam int            TW         = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 2);

    state_t              state_r;
    state_t              state_nx_s;
    logic [4:0]          day_r;
    logic [3:0]          month_r;
    logic [YEARRES-1:0]  year_r;
    logic [4:0]          day_cand_s;
    logic [4:0]          day_nx_s;
    logic [3:0]          month_cand_s;
    logic [YEARRES-1:0]  year_cand_s;
    logic [4:0]          cur_day_s;
    logic [3:0]          cur_month_s;
    logic [YEARRES-1:0]  cur_year_s;
    logic [4:0]          max_cur_s;
    logic [4:0]          max_new_s;
    logic [TW-1:0]       timer_r;
    logic [TW-1:0]       timer_nx_s;
    logic                date_ow_r;
    logic                date_ow_nx_s;
    logic                busy_r;
    logic                busy_nx_s;
    logic [1:0]          field_r;
    logic [1:0]          field_nx_s;
    logic                in_edit_s;
    logic                any_btn_s;
    logic                step_s;
    logic                timeout_s;
    logic                abort_s;
    logic                load_s;

    assign {cur_day_s, cur_month_s, cur_year_s} = bus.date_cur;

    assign any_btn_s = bus.btn_mode | bus.btn_up | bus.btn_down | bus.btn_cancel;
    assign step_s    = ~bus.btn_cancel & ~bus.btn_mode & (bus.btn_up ^ bus.btn_down);
    assign in_edit_s = (state_r == ST_EDIT_DAY) || (state_r == ST_EDIT_MONTH) ||
                       (state_r == ST_EDIT_YEAR);
    assign timeout_s = in_edit_s & ~any_btn_s & (timer_r == TIMER_LAST);
    assign abort_s   = bus.btn_cancel | timeout_s;
    assign load_s    = (state_r == ST_IDLE) & bus.btn_mode & ~bus.btn_cancel;

    // Length of the month being edited, and of the month/year about to be written.
    calendar_set_ctrl_month_len u_len_cur (
        .month   (month_r),
        .leap    (year_r[1:0] == 2'd0),
        .max_day (max_cur_s)
    );

    calendar_set_ctrl_month_len u_len_new (
        .month   (month_cand_s),
        .leap    (year_cand_s[1:0] == 2'd0),
        .max_day (max_new_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: cancel beats mode, timeout only fires with no button.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) state_nx_s = ST_EDIT_DAY;
                else        state_nx_s = ST_IDLE;
            end
            ST_EDIT_DAY: begin
                if (abort_s)           state_nx_s = ST_IDLE;
                else if (bus.btn_mode) state_nx_s = ST_EDIT_MONTH;
                else                   state_nx_s = ST_EDIT_DAY;
            end
            ST_EDIT_MONTH: begin
                if (abort_s)           state_nx_s = ST_IDLE;
                else if (bus.btn_mode) state_nx_s = ST_EDIT_YEAR;
                else                   state_nx_s = ST_EDIT_MONTH;
            end
            ST_EDIT_YEAR: begin
                if (abort_s)           state_nx_s = ST_IDLE;
                else if (bus.btn_mode) state_nx_s = ST_COMMIT;
                else                   state_nx_s = ST_EDIT_YEAR;
            end
            ST_COMMIT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the output flops line up with it.
    always_comb begin
        date_ow_nx_s = (state_nx_s == ST_COMMIT);
        busy_nx_s    = (state_nx_s != ST_IDLE);
        case (state_nx_s)
            ST_EDIT_DAY:   field_nx_s = FLD_DAY;
            ST_EDIT_MONTH: field_nx_s = FLD_MONTH;
            ST_EDIT_YEAR:  field_nx_s = FLD_YEAR;
            default:       field_nx_s = FLD_NONE;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            date_ow_r <= 1'b0;
            busy_r    <= 1'b0;
            field_r   <= FLD_NONE;
        end else begin
            date_ow_r <= date_ow_nx_s;
            busy_r    <= busy_nx_s;
            field_r   <= field_nx_s;
        end
    end

    // Candidate field values: sanitised load from the calendar, or one wrap step.
    always_comb begin
        day_cand_s   = day_r;
        month_cand_s = month_r;
        year_cand_s  = year_r;
        if (load_s) begin
            month_cand_s = ((cur_month_s == 4'd0) || (cur_month_s > MONTH_DEC)) ?
                           MONTH_JAN : cur_month_s;
            year_cand_s  = cur_year_s;
            day_cand_s   = (cur_day_s == 5'd0) ? 5'd1 : cur_day_s;
        end else if (step_s) begin
            case (state_r)
                ST_EDIT_DAY: begin
                    if (bus.btn_up) day_cand_s = (day_r >= max_cur_s) ? 5'd1 : day_r + 5'd1;
                    else            day_cand_s = (day_r <= 5'd1) ? max_cur_s : day_r - 5'd1;
                end
                ST_EDIT_MONTH: begin
                    if (bus.btn_up) month_cand_s = (month_r >= MONTH_DEC) ? MONTH_JAN : month_r + 4'd1;
                    else            month_cand_s = (month_r <= MONTH_JAN) ? MONTH_DEC : month_r - 4'd1;
                end
                ST_EDIT_YEAR: begin
                    if (bus.btn_up) year_cand_s = year_r + YEARRES'(1);
                    else            year_cand_s = year_r - YEARRES'(1);
                end
                default: day_cand_s = day_r;
            endcase
        end else begin
            day_cand_s = day_r;
        end
    end

    // Day is clamped against the month/year it will be paired with.
    assign day_nx_s = (day_cand_s > max_new_s) ? max_new_s : day_cand_s;

    // Edit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            day_r   <= 5'd1;
            month_r <= MONTH_JAN;
            year_r  <= {YEARRES{1'b0}};
        end else begin
            day_r   <= day_nx_s;
            month_r <= month_cand_s;
            year_r  <= year_cand_s;
        end
    end

    // Idle timer: runs only while editing, cleared by any button or a state change.
    always_comb begin
        if (in_edit_s && !any_btn_s && !timeout_s) timer_nx_s = timer_r + TW'(1);
        else                                       timer_nx_s = {TW{1'b0}};
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= {TW{1'b0}};
        end else begin
            timer_r <= timer_nx_s;
        end
    end

    assign bus.date_in    = {day_r, month_r, year_r};
    assign bus.date_ow    = date_ow_r;
    assign bus.edit_field = field_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Bench for calendar_set_ctrl: directed scenarios plus random button traffic,
// all scored against a plain-integer calendar model.
module tb_calendar_set_ctrl;

    localparam int YR   = 12;
    localparam int TO   = 8;
    localparam int YMOD = 1 << YR;

    localparam logic [3:0] BM = 4'b1000;
    localparam logic [3:0] BU = 4'b0100;
    localparam logic [3:0] BD = 4'b0010;
    localparam logic [3:0] BC = 4'b0001;
    localparam logic [3:0] BN = 4'b0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    // model: phase 0 idle, 1 day, 2 month, 3 year, 4 commit
    int m_ph, m_d, m_m, m_y, m_idle;

    always #5 clk = ~clk;

    calendar_set_ctrl_if #(.YEARRES(YR)) bus ();

    calendar_set_ctrl #(.YEARRES(YR), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [YR+12:0] obs = {bus.date_in, bus.date_ow, bus.edit_field, bus.busy};

    function automatic int mdays(int mo, int yr);
        if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [YR+12:0] exp_vec();
        logic [1:0] f;
        f = (m_ph >= 1 && m_ph <= 3) ? 2'(m_ph) : 2'd0;
        return {5'(m_d), 4'(m_m), YR'(m_y), (m_ph == 4), f, (m_ph != 0)};
    endfunction

    task automatic model_reset();
        m_ph = 0; m_d = 1; m_m = 1; m_y = 0; m_idle = 0;
    endtask

    task automatic model_edge(input logic [3:0] b);
        int mx, cd, cm, cy;
        logic md, up, dn, cn;
        {md, up, dn, cn} = b;
        cd = int'(bus.date_cur[YR+8:YR+4]);
        cm = int'(bus.date_cur[YR+3:YR]);
        cy = int'(bus.date_cur[YR-1:0]);
        case (m_ph)
            0: if (md && !cn) begin
                m_m = (cm < 1 || cm > 12) ? 1 : cm;
                m_y = cy;
                mx  = mdays(m_m, m_y);
                m_d = (cd < 1) ? 1 : ((cd > mx) ? mx : cd);
                m_ph = 1; m_idle = 0;
            end
            4: m_ph = 0;
            default: begin
                if (b != 4'b0000) m_idle = 0; else m_idle++;
                if (cn) m_ph = 0;
                else if (md) m_ph++;
                else if (up != dn) begin
                    if (m_ph == 1) begin
                        mx  = mdays(m_m, m_y);
                        m_d = up ? ((m_d == mx) ? 1 : m_d + 1) : ((m_d == 1) ? mx : m_d - 1);
                    end else if (m_ph == 2) begin
                        m_m = up ? (m_m % 12 + 1) : ((m_m == 1) ? 12 : m_m - 1);
                    end else begin
                        m_y = up ? (m_y + 1) % YMOD : (m_y + YMOD - 1) % YMOD;
                    end
                    mx = mdays(m_m, m_y);
                    if (m_d > mx) m_d = mx;
                end else if (m_idle == TO - 1) m_ph = 0;
            end
        endcase
    endtask

    task automatic step(input logic [3:0] b);
        @(negedge clk);
        {bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_cancel} = b;
        @(posedge clk);
        model_edge(b);
        #1;
        {bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_cancel} = 4'b0000;
    endtask

    task automatic set_cur(input int d, input int m, input int y);
        bus.date_cur = {5'(d), 4'(m), YR'(y)};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_cur(9, 9, 99);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h want %h", obs, exp_vec());
        end
        n_cmp++;
        if (obs !== {5'd1, 4'd1, 12'd0, 1'b0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_const: got %h want %h", obs, {5'd1, 4'd1, 12'd0, 4'd0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_entry();
        logic [3:0] seq[$];
        seq = {BM, BU, BU, BU, BM, BD, BM, BU, BM};
        set_cur(15, 6, 2023);
        foreach (seq[i]) begin
            step(seq[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL full_entry[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({bus.date_ow, bus.date_in} !== {1'b1, 5'd18, 4'd5, 12'd2024}) begin
            n_fail++; $display("FAIL full_entry_commit: got ow=%b date=%h want ow=1 date=%h",
                               bus.date_ow, bus.date_in, {5'd18, 4'd5, 12'd2024});
        end
        step(BN);
        n_cmp++;
        if ({bus.date_ow, bus.busy, bus.date_in} !== {1'b0, 1'b0, 5'd18, 4'd5, 12'd2024}) begin
            n_fail++; $display("FAIL full_entry_after: got ow=%b busy=%b date=%h want 0 0 %h",
                               bus.date_ow, bus.busy, bus.date_in, {5'd18, 4'd5, 12'd2024});
        end
    endtask

    task automatic test_clamp_leap();
        set_cur(31, 1, 2023);
        step(BM); step(BM); step(BU);
        n_cmp++;
        if (bus.date_in !== {5'd28, 4'd2, 12'd2023}) begin
            n_fail++; $display("FAIL clamp_feb: got %h want %h", bus.date_in, {5'd28, 4'd2, 12'd2023});
        end
        step(BM); step(BU); step(BM); step(BN);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL clamp_year: got %h want %h", obs, exp_vec());
        end
        set_cur(28, 2, 2024);
        step(BM); step(BM); step(BD); step(BU);
        n_cmp++;
        if (bus.date_in !== {5'd28, 4'd2, 12'd2024}) begin
            n_fail++; $display("FAIL clamp_month_round: got %h want %h", bus.date_in, {5'd28, 4'd2, 12'd2024});
        end
        step(BC);
        step(BM); step(BU);
        n_cmp++;
        if (bus.date_in !== {5'd29, 4'd2, 12'd2024}) begin
            n_fail++; $display("FAIL leap_day29: got %h want %h", bus.date_in, {5'd29, 4'd2, 12'd2024});
        end
        step(BU);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL leap_wrap: got %h want %h", obs, exp_vec());
        end
        step(BC);
        set_cur(29, 2, 2024);
        step(BM); step(BM); step(BM); step(BU);
        n_cmp++;
        if (bus.date_in !== {5'd28, 4'd2, 12'd2025}) begin
            n_fail++; $display("FAIL clamp_nonleap: got %h want %h", bus.date_in, {5'd28, 4'd2, 12'd2025});
        end
        step(BC);
        set_cur(30, 2, 2023); step(BM);
        n_cmp++;
        if (bus.date_in !== {5'd28, 4'd2, 12'd2023}) begin
            n_fail++; $display("FAIL load_clamp: got %h want %h", bus.date_in, {5'd28, 4'd2, 12'd2023});
        end
        step(BC);
        set_cur(0, 0, 7); step(BM);
        n_cmp++;
        if (bus.date_in !== {5'd1, 4'd1, 12'd7}) begin
            n_fail++; $display("FAIL load_zero: got %h want %h", bus.date_in, {5'd1, 4'd1, 12'd7});
        end
        step(BC);
        set_cur(31, 13, 5); step(BM);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL load_month13: got %h want %h", obs, exp_vec());
        end
        step(BC);
    endtask

    task automatic test_wraps();
        logic [3:0] seq[$];
        seq = {BM, BU, BD, BM, BD, BM, BD, BU, BD, BC};
        set_cur(31, 1, 0);
        foreach (seq[i]) begin
            step(seq[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL wraps[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (obs !== {5'd31, 4'd12, 12'd4095, 1'b0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL wraps_final: got %h want %h", obs, {5'd31, 4'd12, 12'd4095, 4'd0});
        end
    endtask

    task automatic test_cancel_timeout();
        logic [3:0] seq[$];
        logic       ow_seen;
        ow_seen = 1'b0;
        seq = {BM, BM, BU, BC, BN, BN};
        set_cur(10, 3, 2000);
        foreach (seq[i]) begin
            step(seq[i]);
            ow_seen |= bus.date_ow;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL cancel[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        step(BM);
        for (int i = 1; i <= TO - 1; i++) begin
            step(BN);
            ow_seen |= bus.date_ow;
            n_cmp++;
            if (bus.busy !== ((i < TO - 1) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL timeout_busy[%0d]: got %b want %b", i, bus.busy, (i < TO - 1));
            end
        end
        n_cmp++;
        if (ow_seen !== 1'b0) begin
            n_fail++; $display("FAIL no_commit_on_abort: got ow_seen=%b want 0", ow_seen);
        end
        seq = {BM, BN, BN, BN, BN, BN, BU, BN, BN, BN, BN, BN, BN, BN, BN};
        foreach (seq[i]) begin
            step(seq[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL timer_restart[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] seq[$];
        seq = {BM, BU | BD, BM | BU, BU | BD, BM | BD, BC | BM, BC | BM, BN};
        set_cur(20, 8, 1999);
        foreach (seq[i]) begin
            step(seq[i]);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL simult[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (obs !== {5'd20, 4'd8, 12'd1999, 1'b0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL simult_final: got %h want %h", obs, {5'd20, 4'd8, 12'd1999, 4'd0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int         r;
            logic [3:0] b;
            if ($urandom_range(0, 7) == 0)
                set_cur(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, YMOD - 1)));
            r = int'($urandom_range(0, 11));
            case (r)
                0, 1:    b = BM;
                2, 3:    b = BU;
                4:       b = BD;
                5:       b = BC;
                6:       b = 4'($urandom);
                default: b = BN;
            endcase
            step(b);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d]: btn=%b got %h want %h", i, b, obs, exp_vec());
            end
        end
        step(BC);
        step(BN);
    endtask

    task automatic test_reset_in_commit();
        set_cur(5, 5, 5);
        repeat (4) step(BM);
        n_cmp++;
        if ({bus.date_ow, bus.busy} !== 2'b11) begin
            n_fail++; $display("FAIL commit_reached: got ow=%b busy=%b want 1 1", bus.date_ow, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (obs !== {5'd1, 4'd1, 12'd0, 1'b0, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_in_commit: got %h want %h", obs, {5'd1, 4'd1, 12'd0, 4'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        step(BN);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL after_reset: got %h want %h", obs, exp_vec());
        end
    endtask

    initial begin
        {bus.btn_mode, bus.btn_up, bus.btn_down, bus.btn_cancel} = 4'b0000;
        bus.date_cur = '0;
        model_reset();
        test_reset();
        test_full_entry();
        test_clamp_leap();
        test_wraps();
        test_cancel_timeout();
        test_simultaneous();
        test_random();
        test_reset_in_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
